bank_xbar_rtn_queue: RTL and testbench
======================================

// Module: bank_xbar_rtn_queue
// PURPOSE
//   Parametrised bank->xbar read-return path; replaces the fixed xbar ready model.
//   Buffers SRAM-controller return beats in per-channel FIFOs.
//   Gates each channel with a credit counter refilled by the xbar.
//   Merges all channels onto one return bus with round-robin arbitration.
// PARAMETERS
//   CH_NUM       3    number of xbar channels (>=2)
//   CH_ID_W      2    channel id width, >= clog2(CH_NUM)
//   ROB_W        3    xbar ROB number width
//   DATA_W       128  return data width
//   DEPTH        4    per-channel FIFO entries (power of 2, >=2)
//   CREDIT_INIT  2    credits per channel after reset
//   CREDIT_MAX   4    credit counter saturation value (>=CREDIT_INIT)
// PORTS
//   clk_i                   in   1               clock
//   rst_n_i                 in   1               async reset, active-low
//   sc_xbar_valid_i         in   1               SC return beat valid
//   sc_xbar_ready_o         out  1               beat accepted when valid&ready
//   sc_xbar_channel_id_i    in   CH_ID_W         destination channel
//   sc_xbar_rob_num_i       in   ROB_W           ROB tag
//   sc_xbar_data_i          in   DATA_W          data
//   xbar_rtn_valid_o        out  1               merged return valid
//   xbar_rtn_ready_i        in   1               xbar accepts beat
//   xbar_rtn_channel_id_o   out  CH_ID_W         granted channel
//   xbar_rtn_rob_num_o      out  ROB_W           ROB tag of head beat
//   xbar_rtn_data_o         out  DATA_W          data of head beat
//   xbar_credit_rtn_i       in   CH_NUM          1-cycle pulse per credit returned, bit=channel
//   credit_ovf_o            out  1               sticky: credit returned while at CREDIT_MAX
// BEHAVIOUR
//   - Reset (async assert, sync release): FIFOs empty, credit[c]=CREDIT_INIT, rr_ptr=0,
//     lock=0, credit_ovf_o=0; xbar_rtn_valid_o=0, sc_xbar_ready_o=1, data/id/rob outputs 0.
//   - sc_xbar_ready_o = !full[sc_xbar_channel_id_i]; never depends on valid or dequeue.
//     Full FIFO + same-cycle dequeue: ready stays 0. channel_id >= CH_NUM: ready=0, dropped never.
//   - Enqueue on valid&ready; beat visible at head next cycle (min in->out latency 1 cycle).
//   - eligible[c] = !empty[c] && credit[c]!=0. Grant = first eligible from rr_ptr upward, wrapping.
//   - Outputs are combinational from granted FIFO head; valid_o = grant exists.
//   - Lock: valid_o && !ready_i sets lock; grant, payload held stable until fire, even if
//     credit_rtn arrives or higher-priority channel becomes eligible.
//   - Fire (valid&ready): pop head, credit[g]-=1, rr_ptr=(g+1) mod CH_NUM, lock cleared.
//   - credit_rtn[c] and fire on c same cycle: credit unchanged. credit_rtn at CREDIT_MAX and no
//     fire: credit stays CREDIT_MAX, credit_ovf_o<=1 until reset.
//   - Per-channel ordering strictly FIFO; no ordering between channels.
//   - Simultaneous enqueue+dequeue same FIFO: both occur, count unchanged; pointers wrap at DEPTH.
//   - Reset mid-transfer discards all buffered beats and restores credits.
// CONFIGURATION
//   BANK_XBAR_RTN_PERF_EN defined: adds output perf_credit_stall_o [CH_NUM*16], per-channel
//     16-bit saturating counters of cycles with !empty[c] && credit[c]==0; reset to 0.
//   Undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//   Shared package bank_pkg: CH_NUM, CH_ID_W, ROB_W, DATA_W defaults; return-beat struct
//     {rob_num, data}; credit width localparam clog2(CREDIT_MAX+1).
//   Sub-module bank_xbar_rtn_fifo: one sync FIFO (DEPTH x ROB_W+DATA_W), full/empty flags;
//     generate-instantiated CH_NUM times. Arbiter, credits, lock live in top.
// TESTING (CH_NUM=3, DEPTH=4, CREDIT_INIT=2, CREDIT_MAX=4)
//   1 Push 3 beats ch1 rob 0,1,2, ready_i=1, no credit_rtn -> rob 0,1 out on ch1, rob 2 held,
//     valid_o=0; pulse credit_rtn[1] -> rob 2 out next cycle.
//   2 One beat each ch0,ch1,ch2 same time, ready_i=1 -> order ch0,ch1,ch2; then
//     two beats each ch0,ch2 (rr_ptr=0) -> order ch0,ch2,ch0,ch2.
//   3 ch2 beat, ready_i=0 for 5 cycles while ch0 becomes eligible -> id/rob/data stable ch2 all
//     5 cycles; fires ch2 first when ready_i=1.
//   4 Fill ch0 with 4 beats, credits 0 -> sc_xbar_ready_o=0 for ch0 id, 1 for ch1 id;
//     credit_rtn[0] -> one pop, ready returns next cycle.
//   5 credit_rtn[2] x3 with no traffic -> credit 4 after 2 pulses, credit_ovf_o=1 after 3rd.
//   6 Assert rst_n_i=0 with 2 beats queued and lock set -> valid_o=0 immediately,
//     credits=2 after release; with PERF_EN, stall counter ch0 counts 10 in 10 blocked cycles.

Source files
------------

// File: rtl/bank_pkg.sv
// Shared defaults, types and helpers for the bank->xbar read-return path.
package bank_pkg;

  localparam int DEF_CH_NUM     = 3;
  localparam int DEF_CH_ID_W    = 2;
  localparam int DEF_ROB_W      = 3;
  localparam int DEF_DATA_W     = 128;
  localparam int DEF_CREDIT_MAX = 4;

  function automatic int credit_width(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

  localparam int DEF_CREDIT_W = credit_width(DEF_CREDIT_MAX);

  typedef struct packed {
    logic [DEF_ROB_W-1:0]  rob_num;
    logic [DEF_DATA_W-1:0] data;
  } rtn_beat_t;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bank_xbar_rtn_queue_if.sv
// Valid/ready return-beat bus, used both for the SC input side and the merged xbar return side.
interface bank_xbar_rtn_queue_if
  import bank_pkg::*;
#(
  parameter int CH_ID_W = DEF_CH_ID_W,
  parameter int ROB_W   = DEF_ROB_W,
  parameter int DATA_W  = DEF_DATA_W
);

  logic               valid;
  logic               ready;
  logic [CH_ID_W-1:0] channel_id;
  logic [ROB_W-1:0]   rob_num;
  logic [DATA_W-1:0]  data;

  modport master (output valid, channel_id, rob_num, data, input ready);
  modport slave  (input valid, channel_id, rob_num, data, output ready);

endinterface

// File: rtl/bank_xbar_rtn_fifo.sv
// Single-clock FIFO holding return beats for one xbar channel; caller never pushes when full or pops when empty.
module bank_xbar_rtn_fifo
  import bank_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DEF_ROB_W + DEF_DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/bank_xbar_rtn_queue.sv
// Bank->xbar read-return queue: per-channel FIFOs, credit gating and round-robin merge with grant lock.
// Optional BANK_XBAR_RTN_PERF_EN adds per-channel credit-stall cycle counters.
module bank_xbar_rtn_queue
  import bank_pkg::*;
#(
  parameter int CH_NUM      = DEF_CH_NUM,
  parameter int CH_ID_W     = DEF_CH_ID_W,
  parameter int ROB_W       = DEF_ROB_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 4,
  parameter int CREDIT_INIT = 2,
  parameter int CREDIT_MAX  = DEF_CREDIT_MAX
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  bank_xbar_rtn_queue_if.slave  sc_xbar,
  bank_xbar_rtn_queue_if.master xbar_rtn,
  input  logic [CH_NUM-1:0]     xbar_credit_rtn_i,
  output logic                  credit_ovf_o
`ifdef BANK_XBAR_RTN_PERF_EN
  ,
  output logic [CH_NUM*16-1:0]  perf_credit_stall_o
`endif
);

  localparam int CRED_W = credit_width(CREDIT_MAX);
  localparam int BEAT_W = ROB_W + DATA_W;

  logic [CH_NUM-1:0]  push, pop, full, empty, eligible;
  logic [BEAT_W-1:0]  head [CH_NUM];
  logic [BEAT_W-1:0]  head_sel;
  logic [CRED_W-1:0]  credit [CH_NUM];
  logic [CH_ID_W-1:0] rr_ptr, lock_idx, arb_idx, sel;
  logic               sc_ready, arb_any, rtn_valid, fire;
  arb_state_e         state_q, state_d;

  // Ready looks only at the addressed FIFO's full flag; unknown channel ids are never accepted.
  always_comb begin
    sc_ready = 1'b0;
    push     = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (sc_xbar.channel_id == CH_ID_W'(c)) begin
        sc_ready = !full[c];
        push[c]  = sc_xbar.valid && !full[c];
      end
    end
  end

  assign sc_xbar.ready = sc_ready;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_fifo
    bank_xbar_rtn_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (BEAT_W)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push    (push[c]),
      .wdata   ({sc_xbar.rob_num, sc_xbar.data}),
      .pop     (pop[c]),
      .rdata   (head[c]),
      .full    (full[c]),
      .empty   (empty[c])
    );
    assign eligible[c] = !empty[c] && (credit[c] != '0);
  end

  always_comb begin
    int idx;
    arb_any = 1'b0;
    arb_idx = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= CH_NUM) idx = idx - CH_NUM;
      for (int c = 0; c < CH_NUM; c++) begin
        if (!arb_any && (c == idx) && eligible[c]) begin
          arb_any = 1'b1;
          arb_idx = CH_ID_W'(c);
        end
      end
    end
  end

  // A locked grant stays put until it fires; its FIFO and credit cannot drain in the meantime.
  assign sel       = (state_q == ARB_LOCKED) ? lock_idx : arb_idx;
  assign rtn_valid = (state_q == ARB_LOCKED) || arb_any;
  assign fire      = rtn_valid && xbar_rtn.ready;

  always_comb begin
    head_sel = '0;
    pop      = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (sel == CH_ID_W'(c)) begin
        head_sel = head[c];
        pop[c]   = fire;
      end
    end
  end

  assign xbar_rtn.valid      = rtn_valid;
  assign xbar_rtn.channel_id = rtn_valid ? sel : '0;
  assign {xbar_rtn.rob_num, xbar_rtn.data} = rtn_valid ? head_sel : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ARB_FREE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_FREE:   if (rtn_valid && !xbar_rtn.ready) state_d = ARB_LOCKED;
      ARB_LOCKED: if (fire) state_d = ARB_FREE;
      default:    state_d = ARB_FREE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      if (state_q == ARB_FREE) lock_idx <= arb_idx;
      if (fire) rr_ptr <= (sel == CH_ID_W'(CH_NUM-1)) ? '0 : sel + CH_ID_W'(1);
    end
  end

  // A return and a consume on the same channel in one cycle cancel out.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CH_NUM; c++) credit[c] <= CRED_W'(CREDIT_INIT);
      credit_ovf_o <= 1'b0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (pop[c] && !xbar_credit_rtn_i[c]) begin
          credit[c] <= credit[c] - CRED_W'(1);
        end else if (!pop[c] && xbar_credit_rtn_i[c]) begin
          if (credit[c] == CRED_W'(CREDIT_MAX)) credit_ovf_o <= 1'b1;
          else                                  credit[c] <= credit[c] + CRED_W'(1);
        end
      end
    end
  end

`ifdef BANK_XBAR_RTN_PERF_EN
  for (genvar c = 0; c < CH_NUM; c++) begin : g_perf
    logic [15:0] stall_cnt;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        stall_cnt <= '0;
      end else if (!empty[c] && (credit[c] == '0) && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
    assign perf_credit_stall_o[c*16 +: 16] = stall_cnt;
  end
`endif

endmodule

// File: tb/tb_bank_xbar_rtn_queue.sv
// Directed bench for bank_xbar_rtn_queue with CH_NUM=3, DEPTH=4, CREDIT_INIT=2, CREDIT_MAX=4.
module tb_bank_xbar_rtn_queue;
  import bank_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] credit_rtn;
  logic       credit_ovf;
  int         checks;
  int         errors;
`ifdef BANK_XBAR_RTN_PERF_EN
  logic [47:0] perf;
`endif

  bank_xbar_rtn_queue_if #(.CH_ID_W(2), .ROB_W(3), .DATA_W(128)) sc_if ();
  bank_xbar_rtn_queue_if #(.CH_ID_W(2), .ROB_W(3), .DATA_W(128)) rtn_if ();

  bank_xbar_rtn_queue #(
    .CH_NUM(3), .CH_ID_W(2), .ROB_W(3), .DATA_W(128),
    .DEPTH(4), .CREDIT_INIT(2), .CREDIT_MAX(4)
  ) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .sc_xbar           (sc_if),
    .xbar_rtn          (rtn_if),
    .xbar_credit_rtn_i (credit_rtn),
    .credit_ovf_o      (credit_ovf)
`ifdef BANK_XBAR_RTN_PERF_EN
    ,
    .perf_credit_stall_o (perf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected end of sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] beatData(input int ch, input int rob);
    return {64'hFEED_0000_0000_0000 + 64'(ch * 256 + rob), 64'hA5A5_5A5A_0F0F_F0F0 ^ 64'(ch * 8 + rob)};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input int ch, input int rob, input logic rdy,
                               input logic [2:0] crtn);
    sc_if.valid      = v;
    sc_if.channel_id = 2'(ch);
    sc_if.rob_num    = 3'(rob);
    sc_if.data       = beatData(ch, rob);
    rtn_if.ready     = rdy;
    credit_rtn       = crtn;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleNow();
    @(negedge clk);
  endtask

  task automatic expectBeat(input string tag, input int ch, input int rob);
    checkOutput({tag, ".valid"}, 128'(rtn_if.valid), 128'(1));
    checkOutput({tag, ".id"}, 128'(rtn_if.channel_id), 128'(ch));
    checkOutput({tag, ".rob"}, 128'(rtn_if.rob_num), 128'(rob));
    checkOutput({tag, ".data"}, rtn_if.data, beatData(ch, rob));
  endtask

  task automatic expectIdle(input string tag);
    checkOutput({tag, ".valid"}, 128'(rtn_if.valid), 128'(0));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.valid", 128'(rtn_if.valid), 128'(0));
    checkOutput("rst.sc_ready", 128'(sc_if.ready), 128'(1));
    checkOutput("rst.id", 128'(rtn_if.channel_id), 128'(0));
    checkOutput("rst.rob", 128'(rtn_if.rob_num), 128'(0));
    checkOutput("rst.data", rtn_if.data, 128'(0));
    checkOutput("rst.ovf", 128'(credit_ovf), 128'(0));
    rst_n = 1'b1;
    nextCycle();

    $display("[TB] test 1: credit gating on ch1");
    applyStimulus(1'b1, 1, 0, 1'b1, 3'b000);
    sampleNow(); expectIdle("t1.empty"); nextCycle();
    applyStimulus(1'b1, 1, 1, 1'b1, 3'b000);
    sampleNow(); expectBeat("t1.rob0", 1, 0); nextCycle();
    applyStimulus(1'b1, 1, 2, 1'b1, 3'b000);
    sampleNow(); expectBeat("t1.rob1", 1, 1); nextCycle();
    applyStimulus(1'b0, 1, 0, 1'b1, 3'b000);
    sampleNow(); expectIdle("t1.held");
    checkOutput("t1.sc_ready", 128'(sc_if.ready), 128'(1));
    nextCycle();
    applyStimulus(1'b0, 1, 0, 1'b1, 3'b010);
    sampleNow(); expectIdle("t1.pulse"); nextCycle();
    applyStimulus(1'b0, 1, 0, 1'b1, 3'b000);
    sampleNow(); expectBeat("t1.rob2", 1, 2); nextCycle();
    sampleNow(); expectIdle("t1.drained"); nextCycle();

    $display("[TB] test 2: round-robin order");
    doReset();
    applyStimulus(1'b1, 0, 3, 1'b0, 3'b000); nextCycle();
    applyStimulus(1'b1, 1, 4, 1'b0, 3'b000); nextCycle();
    applyStimulus(1'b1, 2, 5, 1'b0, 3'b000); nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b000);
    sampleNow(); expectBeat("t2.a0", 0, 3); nextCycle();
    sampleNow(); expectBeat("t2.a1", 1, 4); nextCycle();
    sampleNow(); expectBeat("t2.a2", 2, 5); nextCycle();
    sampleNow(); expectIdle("t2.a_done");
    applyStimulus(1'b0, 0, 0, 1'b0, 3'b101); nextCycle();
    applyStimulus(1'b1, 0, 1, 1'b0, 3'b000); nextCycle();
    applyStimulus(1'b1, 0, 2, 1'b0, 3'b000); nextCycle();
    applyStimulus(1'b1, 2, 5, 1'b0, 3'b000); nextCycle();
    applyStimulus(1'b1, 2, 6, 1'b0, 3'b000); nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b000);
    sampleNow(); expectBeat("t2.b0", 0, 1); nextCycle();
    sampleNow(); expectBeat("t2.b1", 2, 5); nextCycle();
    sampleNow(); expectBeat("t2.b2", 0, 2); nextCycle();
    sampleNow(); expectBeat("t2.b3", 2, 6); nextCycle();
    sampleNow(); expectIdle("t2.b_done");

    $display("[TB] test 3: grant lock under backpressure");
    doReset();
    applyStimulus(1'b1, 2, 7, 1'b0, 3'b000); nextCycle();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) applyStimulus(1'b1, 0, 3, 1'b0, 3'b000);
      else        applyStimulus(1'b0, 0, 0, 1'b0, 3'b000);
      sampleNow(); expectBeat($sformatf("t3.hold%0d", i), 2, 7); nextCycle();
    end
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b000);
    sampleNow(); expectBeat("t3.fire", 2, 7); nextCycle();
    sampleNow(); expectBeat("t3.next", 0, 3); nextCycle();
    sampleNow(); expectIdle("t3.done");

    $display("[TB] test 4: full FIFO backpressure");
    doReset();
    for (int r = 0; r < 6; r++) begin
      applyStimulus(1'b1, 0, r, 1'b1, 3'b000);
      sampleNow(); checkOutput($sformatf("t4.accept%0d", r), 128'(sc_if.ready), 128'(1)); nextCycle();
    end
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b000);
    sampleNow();
    checkOutput("t4.full_ch0", 128'(sc_if.ready), 128'(0));
    expectIdle("t4.blocked");
    nextCycle();
    applyStimulus(1'b0, 1, 0, 1'b1, 3'b000);
    sampleNow(); checkOutput("t4.ch1_ready", 128'(sc_if.ready), 128'(1)); nextCycle();
    applyStimulus(1'b1, 3, 0, 1'b1, 3'b000);
    sampleNow(); checkOutput("t4.bad_id", 128'(sc_if.ready), 128'(0)); nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b001);
    sampleNow(); checkOutput("t4.still_full", 128'(sc_if.ready), 128'(0)); nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b000);
    sampleNow();
    expectBeat("t4.pop", 0, 2);
    checkOutput("t4.full_during_pop", 128'(sc_if.ready), 128'(0));
    nextCycle();
    sampleNow();
    checkOutput("t4.ready_back", 128'(sc_if.ready), 128'(1));
    expectIdle("t4.one_credit_used");

    $display("[TB] test 5: credit saturation and overflow flag");
    doReset();
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b100); nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b000);
    sampleNow(); checkOutput("t5.ovf_after1", 128'(credit_ovf), 128'(0)); nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b100); nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b000);
    sampleNow(); checkOutput("t5.ovf_after2", 128'(credit_ovf), 128'(0)); nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b100); nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b000);
    sampleNow(); checkOutput("t5.ovf_after3", 128'(credit_ovf), 128'(1)); nextCycle();
    for (int r = 0; r < 4; r++) begin
      applyStimulus(1'b1, 2, r, 1'b0, 3'b000); nextCycle();
    end
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b000);
    for (int r = 0; r < 4; r++) begin
      sampleNow(); expectBeat($sformatf("t5.drain%0d", r), 2, r); nextCycle();
    end
    sampleNow(); expectIdle("t5.drained");
    applyStimulus(1'b1, 2, 4, 1'b1, 3'b000); nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b000);
    sampleNow();
    expectIdle("t5.no_credit");
    checkOutput("t5.ovf_sticky", 128'(credit_ovf), 128'(1));
    nextCycle();

    $display("[TB] test 6: reset mid-transfer");
    doReset();
    applyStimulus(1'b1, 0, 1, 1'b0, 3'b000); nextCycle();
    applyStimulus(1'b1, 0, 2, 1'b0, 3'b000); nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b0, 3'b000);
    sampleNow(); expectBeat("t6.locked", 0, 1);
    #1 rst_n = 1'b0;
    #1;
    expectIdle("t6.async");
    checkOutput("t6.async_id", 128'(rtn_if.channel_id), 128'(0));
    checkOutput("t6.async_data", rtn_if.data, 128'(0));
    checkOutput("t6.async_sc_ready", 128'(sc_if.ready), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    sampleNow(); expectIdle("t6.flushed"); nextCycle();
    applyStimulus(1'b1, 0, 5, 1'b0, 3'b000); nextCycle();
    applyStimulus(1'b1, 0, 6, 1'b0, 3'b000); nextCycle();
    applyStimulus(1'b1, 0, 7, 1'b0, 3'b000); nextCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 3'b000);
    sampleNow(); expectBeat("t6.new0", 0, 5); nextCycle();
    sampleNow(); expectBeat("t6.new1", 0, 6); nextCycle();
    sampleNow(); expectIdle("t6.credit_limit");
`ifdef BANK_XBAR_RTN_PERF_EN
    checkOutput("t6.stall_start", 128'(perf[15:0]), 128'(0));
    repeat (10) nextCycle();
    sampleNow();
    checkOutput("t6.stall_ch0", 128'(perf[15:0]), 128'(10));
    checkOutput("t6.stall_ch1", 128'(perf[31:16]), 128'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
